// File: rtl/step_ctrl_pkg.sv
// Shared types and widths for the step motion sequencer.
package step_ctrl_pkg;

  localparam int unsigned POS_W    = 32;
  localparam int unsigned PERIOD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ACCEL,
    CRUISE,
    DECEL,
    DONE
  } stateT;

  function automatic logic isMoving(input stateT s);
    return (s == ACCEL) || (s == CRUISE) || (s == DECEL);
  endfunction

endpackage

// File: rtl/step_interval_timer.sv
// Step interval timer: counts cycles against the interval and raises a registered tick
// in the cycle the count reaches period-1. All inputs describe the upcoming cycle.
module step_interval_timer
  import step_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                run,
  input  logic                mask,
  input  logic [PERIOD_W-1:0] period,
  output logic                tickRaw,
  output logic                tickOut
);

  logic [PERIOD_W-1:0] timer;
  logic [PERIOD_W-1:0] timerNext;
  logic                hit;

  // A tick or a fresh command restarts the count for the next interval.
  always_comb begin
    timerNext = (clear || tickRaw) ? '0 : timer + PERIOD_W'(1);
    hit       = (timerNext == period - PERIOD_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer   <= '0;
      tickRaw <= 1'b0;
      tickOut <= 1'b0;
    end else if (!run) begin
      timer   <= '0;
      tickRaw <= 1'b0;
      tickOut <= 1'b0;
    end else begin
      timer   <= timerNext;
      tickRaw <= hit;
      tickOut <= hit && !mask;
    end
  end

endmodule

// File: rtl/step_motion_ctrl.sv
// Trapezoidal-ramp step sequencer with absolute position tracking and decelerated abort.
// Build option: define SOFT_LIMIT_EN to add POS_LO/POS_HI travel limits and the limit_hit output.
module step_motion_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int unsigned          CNT_W     = 24,
  parameter logic [PERIOD_W-1:0]  P_START   = 32'd400000,
  parameter logic [PERIOD_W-1:0]  P_MIN     = 32'd200000,
  parameter logic [PERIOD_W-1:0]  ACC_DELTA = 32'd10000
`ifdef SOFT_LIMIT_EN
  ,
  parameter logic signed [POS_W-1:0] POS_LO = -32'sd100000,
  parameter logic signed [POS_W-1:0] POS_HI = 32'sd100000
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [CNT_W-1:0]        cmd_steps,
  input  logic                    abort,
  output logic                    step_tick,
  output logic                    step_dir,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position
`ifdef SOFT_LIMIT_EN
  ,
  output logic                    limit_hit
`endif
);

  if (P_MIN == '0 || P_MIN > P_START) begin : gBadPeriod
    $error("step_motion_ctrl: need 0 < P_MIN <= P_START");
  end
`ifdef SOFT_LIMIT_EN
  if (POS_LO > POS_HI) begin : gBadLimit
    $error("step_motion_ctrl: need POS_LO <= POS_HI");
  end
`endif

  stateT                    state, stateN;
  logic [CNT_W-1:0]         rem, remN, ramp, rampN, remDec;
  logic [PERIOD_W-1:0]      period, periodN, periodUp, periodDn;
  logic [PERIOD_W:0]        periodSum;
  logic [CNT_W:0]           abortCap;
  logic signed [POS_W-1:0]  posN;
  logic                     dirN, busyN, doneN, readyN;
  logic                     clear, run, mask, tickRaw;
`ifdef SOFT_LIMIT_EN
  logic                     limitN;
`endif

  // Saturating ramp arithmetic kept out of the FSM body.
  assign remDec    = rem - CNT_W'(1);
  assign periodSum = {1'b0, period} + {1'b0, ACC_DELTA};
  assign periodUp  = (periodSum > {1'b0, P_START}) ? P_START : periodSum[PERIOD_W-1:0];
  assign periodDn  = (period < ACC_DELTA || (period - ACC_DELTA) < P_MIN) ? P_MIN
                                                                          : period - ACC_DELTA;

  step_interval_timer uTimer (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .run     (run),
    .mask    (mask),
    .period  (periodN),
    .tickRaw (tickRaw),
    .tickOut (step_tick)
  );

  always_comb begin
    stateN   = state;
    remN     = rem;
    rampN    = ramp;
    periodN  = period;
    posN     = position;
    dirN     = step_dir;
    busyN    = busy;
    doneN    = 1'b0;
    readyN   = cmd_ready;
    clear    = 1'b0;
    abortCap = '0;
`ifdef SOFT_LIMIT_EN
    limitN   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          dirN    = cmd_dir;
          remN    = cmd_steps;
          periodN = P_START;
          rampN   = '0;
          readyN  = 1'b0;
          clear   = 1'b1;
          if (cmd_steps == '0) begin
            stateN = DONE;
            doneN  = 1'b1;
          end else begin
            stateN = ACCEL;
            busyN  = 1'b1;
          end
        end
      end
      ACCEL, CRUISE, DECEL: begin
        if (tickRaw) begin
`ifdef SOFT_LIMIT_EN
          // A masked tick means the step would leave the travel window.
          if (!step_tick) begin
            stateN = DONE;
            doneN  = 1'b1;
            limitN = 1'b1;
          end else begin
`else
          begin
`endif
            posN = step_dir ? position + POS_W'(1) : position - POS_W'(1);
            remN = remDec;
            if (remDec == '0) begin
              stateN = DONE;
              doneN  = 1'b1;
            end else if (state == DECEL || remDec <= ramp) begin
              stateN  = DECEL;
              periodN = periodUp;
              rampN   = (ramp == '0) ? '0 : ramp - CNT_W'(1);
            end else if (state == ACCEL) begin
              periodN = periodDn;
              rampN   = ramp + CNT_W'(1);
              if (periodDn == P_MIN) stateN = CRUISE;
            end
          end
        end
        // Abort leaves just enough steps to walk the ramp back down.
        abortCap = {1'b0, rampN} + (CNT_W+1)'(1);
        if (abort && stateN != DONE && {1'b0, remN} > abortCap) begin
          remN = rampN + CNT_W'(1);
        end
      end
      DONE: begin
        stateN = IDLE;
        busyN  = 1'b0;
        readyN = 1'b1;
      end
      default: stateN = IDLE;
    endcase
    run = isMoving(stateN);
`ifdef SOFT_LIMIT_EN
    mask = dirN ? (posN >= POS_HI) : (posN <= POS_LO);
`else
    mask = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      step_dir  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      position  <= '0;
      period    <= P_START;
      ramp      <= '0;
      rem       <= '0;
`ifdef SOFT_LIMIT_EN
      limit_hit <= 1'b0;
`endif
    end else begin
      state     <= stateN;
      cmd_ready <= readyN;
      step_dir  <= dirN;
      busy      <= busyN;
      done      <= doneN;
      position  <= posN;
      period    <= periodN;
      ramp      <= rampN;
      rem       <= remN;
`ifdef SOFT_LIMIT_EN
      limit_hit <= limitN;
`endif
    end
  end

endmodule

// File: tb/tb_step_motion_ctrl.sv
// Bench for step_motion_ctrl: event-scheduled reference model checked every cycle plus
// hand-derived ramp profiles. Define SOFT_LIMIT_EN to exercise the travel-limit build.
module tb_step_motion_ctrl;

  localparam int P_START_T = 10;
  localparam int P_MIN_T   = 4;
  localparam int ACC_T     = 2;
`ifdef SOFT_LIMIT_EN
  localparam int POS_LO_T  = -8;
  localparam int POS_HI_T  = 5;
`endif
  localparam int M_IDLE = 0, M_ACC = 1, M_CRU = 2, M_DEC = 3, M_DONE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] cmd_steps = '0;
  logic        cmd_ready, step_tick, step_dir, busy, done;
  logic [31:0] position;
`ifdef SOFT_LIMIT_EN
  logic        limit_hit;
`endif

  int checks = 0;
  int errors = 0;

  step_motion_ctrl #(
    .CNT_W     (24),
    .P_START   (32'd10),
    .P_MIN     (32'd4),
    .ACC_DELTA (32'd2)
`ifdef SOFT_LIMIT_EN
    ,
    .POS_LO    (-32'sd8),
    .POS_HI    (32'sd5)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .abort     (abort),
    .step_tick (step_tick),
    .step_dir  (step_dir),
    .busy      (busy),
    .done      (done),
    .position  (position)
`ifdef SOFT_LIMIT_EN
    ,
    .limit_hit (limit_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: move state plus the absolute cycle of the next step.
  longint cyc = 0;
  longint mNext = -1;
  int     mMode = M_IDLE;
  int     mRem = 0, mRamp = 0, mPeriod = P_START_T, mPos = 0;
  bit     mDir = 0, mBusy = 0, mLimit = 0;

  function automatic bit wouldBlock(input int pos, input bit d);
`ifdef SOFT_LIMIT_EN
    return d ? (longint'(pos) + 1 > POS_HI_T) : (longint'(pos) - 1 < POS_LO_T);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit mMoving();
    return mMode == M_ACC || mMode == M_CRU || mMode == M_DEC;
  endfunction

  task automatic modelReset();
    mMode = M_IDLE; mRem = 0; mRamp = 0; mPeriod = P_START_T; mPos = 0;
    mDir = 0; mBusy = 0; mLimit = 0; mNext = -1;
  endtask

  task automatic modelStep();
    if (mMode == M_IDLE) begin
      if (cmd_valid) begin
        mDir = cmd_dir; mRem = int'(cmd_steps); mPeriod = P_START_T; mRamp = 0; mLimit = 0;
        if (mRem == 0) mMode = M_DONE;
        else begin
          mMode = M_ACC; mBusy = 1; mNext = cyc + P_START_T;
        end
      end
    end else if (mMode == M_DONE) begin
      mMode = M_IDLE; mBusy = 0; mLimit = 0;
    end else begin
      if (cyc == mNext) begin
        if (wouldBlock(mPos, mDir)) begin
          mMode = M_DONE; mLimit = 1;
        end else begin
          mPos = mDir ? mPos + 1 : mPos - 1;
          mRem = mRem - 1;
          if (mRem == 0) mMode = M_DONE;
          else if (mMode == M_DEC || mRem <= mRamp) begin
            mMode = M_DEC;
            mPeriod = (mPeriod + ACC_T > P_START_T) ? P_START_T : mPeriod + ACC_T;
            mRamp = (mRamp > 0) ? mRamp - 1 : 0;
          end else if (mMode == M_ACC) begin
            mPeriod = (mPeriod - ACC_T < P_MIN_T) ? P_MIN_T : mPeriod - ACC_T;
            mRamp = mRamp + 1;
            if (mPeriod == P_MIN_T) mMode = M_CRU;
          end
          mNext = cyc + mPeriod;
        end
      end
      if (abort && mMode != M_DONE && mRem > mRamp + 1) mRem = mRamp + 1;
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    bit expTick;
    if (rst) modelReset();
    expTick = mMoving() && cyc == mNext && !wouldBlock(mPos, mDir);
    chk("step_tick", longint'(step_tick), longint'(expTick));
    chk("busy", longint'(busy), longint'(mBusy));
    chk("done", longint'(done), longint'(mMode == M_DONE));
    chk("cmd_ready", longint'(cmd_ready), longint'(mMode == M_IDLE));
    chk("step_dir", longint'(step_dir), longint'(mDir));
    chk("position", longint'($signed(position)), longint'(mPos));
`ifdef SOFT_LIMIT_EN
    chk("limit_hit", longint'(limit_hit), longint'(mMode == M_DONE && mLimit));
`endif
    if (!rst) modelStep();
    cyc++;
  end

  // Directed move capture: step intervals, done latency and state at done.
  int     tickIv[$];
  int     doneGap;
  longint posAtDone;
  bit     dirAtDone, limAtDone;

  task automatic doMove(input bit d, input int steps, input int abortTick, input int abortGap);
    int k, lastK, abortAt, w;
    bit got;
    tickIv.delete();
    got = 0; lastK = 0; abortAt = -1; doneGap = -1; posAtDone = 0; dirAtDone = 0; limAtDone = 0;
    w = 0;
    while (!cmd_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk); #1;
    cmd_valid = 1; cmd_dir = d; cmd_steps = 24'(steps);
    @(posedge clk); #1;
    cmd_valid = 0;
    for (k = 1; k <= 3000; k++) begin
      abort = (k == abortAt);
      @(negedge clk);
      if (step_tick) begin
        tickIv.push_back(k - lastK);
        lastK = k;
        if (tickIv.size() == abortTick && abortGap > 0) abortAt = k + abortGap;
      end
      if (done) begin
        got = 1;
        doneGap = k - lastK;
        posAtDone = longint'($signed(position));
        dirAtDone = step_dir;
`ifdef SOFT_LIMIT_EN
        limAtDone = limit_hit;
`endif
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    abort = 0;
    if (!got) chk("move_timeout", 0, 1);
  endtask

  task automatic chkIv(input string tag, input int exp[$]);
    chk({tag, "_ticks"}, tickIv.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < tickIv.size()) chk($sformatf("%s_iv%0d", tag, i), tickIv[i], exp[i]);
  endtask

  initial begin
    int expIv[$];
    int nTicks;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready", longint'(cmd_ready), 1);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_pos", longint'($signed(position)), 0);
    chk("rst_tick", longint'(step_tick), 0);

`ifdef SOFT_LIMIT_EN
    doMove(1, 10, 0, 0);
    expIv = '{10, 8, 6, 4, 4};
    chkIv("lim", expIv);
    chk("lim_gap", doneGap, 5);
    chk("lim_hit", longint'(limAtDone), 1);
    chk("lim_pos", posAtDone, 5);
`else
    doMove(1, 20, 0, 0);
    expIv = '{10, 8, 6, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 6, 8, 10};
    chkIv("m20", expIv);
    chk("m20_gap", doneGap, 1);
    chk("m20_pos", posAtDone, 20);

    doMove(0, 4, 0, 0);
    expIv = '{10, 8, 6, 8};
    chkIv("m4", expIv);
    chk("m4_pos", posAtDone, 16);
    chk("m4_dir", longint'(dirAtDone), 0);

    doMove(1, 0, 0, 0);
    chk("m0_ticks", tickIv.size(), 0);
    chk("m0_gap", doneGap, 1);
    chk("m0_pos", posAtDone, 16);

    doMove(1, 100, 10, 2);
    expIv = '{10, 8, 6, 4, 4, 4, 4, 4, 4, 4, 4, 6, 8, 10};
    chkIv("abort", expIv);
    chk("abort_pos", posAtDone, 30);
`endif

    // Reset asserted between clock edges in the middle of a move.
    @(posedge clk); #1;
    cmd_valid = 1; cmd_dir = 1; cmd_steps = 24'd100;
    @(posedge clk); #1;
    cmd_valid = 0;
    repeat (37) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("mid_rst_tick", longint'(step_tick), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_pos", longint'($signed(position)), 0);
    chk("mid_rst_ready", longint'(cmd_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    nTicks = 0;
    repeat (50) begin
      @(negedge clk);
      if (step_tick) nTicks++;
    end
    chk("post_rst_ticks", nTicks, 0);

    // Random commands, aborts and ignored traffic, checked by the model each cycle.
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #1;
      cmd_valid = ($urandom_range(0, 7) == 0);
      cmd_dir   = 1'($urandom_range(0, 1));
      cmd_steps = 24'($urandom_range(0, 30));
      abort     = ($urandom_range(0, 63) == 0);
    end
    @(posedge clk); #1;
    cmd_valid = 0; abort = 0;
    repeat (400) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_motion_ctrl.md
Name: step_motion_ctrl

Overview:
Trapezoidal-ramp motion sequencer for the half-step phase driver. Accepts relative move commands over a valid/ready handshake. Emits one-cycle step strobes plus a direction level to the phase driver, with accel/cruise/decel timing. Tracks absolute position and supports controlled abort with deceleration.

Parameters:
CNT_W, 24, width of the step-count field in a move command
P_START, 32'd400000, start/stop step interval in clk cycles (125 Hz at 50 MHz)
P_MIN, 32'd200000, cruise step interval in clk cycles (250 Hz at 50 MHz); must be <= P_START
ACC_DELTA, 32'd10000, interval change per step during ramps

Ports:
clk  in  1  system clock (single clock domain)
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  move command valid
cmd_ready  out  1  high when a command can be accepted (IDLE only)
cmd_dir  in  1  1 = forward (+), 0 = reverse (-)
cmd_steps  in  CNT_W  number of steps to move
abort  in  1  request decelerated stop of the current move
step_tick  out  1  one-cycle strobe, one step per pulse
step_dir  out  1  direction level, stable for the whole move
busy  out  1  high from command accept until done
done  out  1  one-cycle pulse at end of move
position  out  32  signed absolute position in steps

Behaviour:
- Reset values:
  - state IDLE, cmd_ready=1, step_tick=0, step_dir=0, busy=0, done=0, position=0.
  - Internal: period=P_START, ramp=0, rem=0, timer=0.
- Accept: cmd_valid && cmd_ready in cycle N.
  - Latch dir and rem=cmd_steps; set period=P_START, ramp=0, timer=0.
  - busy=1 and cmd_ready=0 from N+1.
- cmd_steps==0: no ticks; done pulses in N+1; busy stays 0; back to IDLE in N+2.
- States: IDLE, ACCEL, CRUISE, DECEL, DONE. Accept with nonzero steps enters ACCEL.
- Timer: increments each cycle while moving.
  - When timer==period-1: step_tick=1 that cycle, timer returns to 0.
  - First tick occurs P_START cycles after accept (cycle N+P_START).
- On each tick:
  - position += dir ? +1 : -1, wrapping mod 2^32.
  - rem' = rem-1, then the first matching rule applies:
    - rem'==0 -> DONE.
    - state==DECEL or rem' <= ramp -> DECEL: period=min(period+ACC_DELTA, P_START); ramp=max(ramp-1, 0).
    - ACCEL -> period=max(period-ACC_DELTA, P_MIN); ramp=ramp+1; if the new period equals P_MIN -> CRUISE.
    - CRUISE -> unchanged.
- DONE: done=1 for one cycle, busy=0 the next cycle, return to IDLE. Back-to-back commands are accepted no earlier than the cycle after done.
- Abort (only while busy):
  - rem = min(rem, ramp+1); the current interval completes normally.
  - Same cycle as a tick: apply the tick update first, then rem = min(rem', ramp_after+1).
  - Ignored in IDLE and DONE.
- cmd_valid while busy: ignored; held off by cmd_ready=0.
- step_dir: updated only on accept.
- rst mid-move: all state returns to reset values immediately; no further ticks.
- All interval arithmetic is 32-bit unsigned, with saturation as stated. Parameter legality is checked at elaboration.

Optional Feature:
SOFT_LIMIT_EN
- Defined: adds parameters POS_LO (default -32'sd100000) and POS_HI (default 32'sd100000), and output port limit_hit (1 bit, reset 0).
  - A tick that would move position below POS_LO or above POS_HI is suppressed: no step_tick, position unchanged.
  - The FSM goes straight to DONE; limit_hit pulses in the same cycle as done.
- Undefined: no limit logic, no limit_hit port; position wraps freely.

Decomposition:
- Package step_ctrl_pkg: state enum (IDLE, ACCEL, CRUISE, DECEL, DONE), POS_W=32, PERIOD_W=32.
- Sub-module step_interval_timer: holds timer, compares against period, produces tick; inputs clear/run/period.
- The FSM and ramp/rem/position logic stay in step_motion_ctrl.

Test Plan:
Sim parameters: P_START=10, P_MIN=4, ACC_DELTA=2.
- Reset: rst high mid-cycle -> immediately step_tick=0, busy=0, position=0, cmd_ready=1; no tick for 50 cycles after release.
- cmd_steps=20, dir=1 -> intervals 10,8,6, fourteen at 4, then 6,8,10. Exactly 20 ticks; done one cycle after tick 20; position=20.
- cmd_steps=4, dir=0 from position 20 -> intervals 10,8,6,8; position=16; step_dir=0 throughout.
- cmd_steps=0 -> no ticks, done in the cycle after accept, position unchanged.
- cmd_steps=100, abort asserted 2 cycles after tick 10 (cruise, ramp=3) -> the current 4-cycle interval completes, then 6,8,10. Total 14 ticks; position +14.
- SOFT_LIMIT_EN with POS_HI=5, cmd_steps=10 from position 0 -> 5 ticks; the 6th is suppressed; done and limit_hit pulse together; position=5.
